br_resolve_unit: RTL and testbench

//  Resolution end of the branch-prediction interface. Queues each fetch-time prediction (dir + target) in program order.

---
 rtl/br_resolve_unit_pkg.sv | 15 +
 rtl/br_resolve_unit_pred_queue.sv | 44 ++++
 rtl/br_resolve_unit.sv | 106 ++++++++++
 tb/tb_br_resolve_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/br_resolve_unit_pkg.sv
// br_resolve_unit_pkg: shared types and opcodes for branch resolution.
package br_resolve_unit_pkg;
   localparam logic [6:0] op_br   = 7'b1100011;
   localparam logic [6:0] op_jal  = 7'b1101111;
   localparam logic [6:0] op_jalr = 7'b1100111;
   typedef struct packed {
      logic [31:0] pc;
      logic        dir;
      logic [31:0] tgt;
   } brq_entry_t;
   typedef enum logic {BRR_RUN, BRR_RECOVER} brr_state_t;
   function automatic logic [31:0] fall_thru(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/br_resolve_unit_pred_queue.sv
// br_pred_queue: in-order FIFO of fetch-time predictions with flash clear.
module br_pred_queue
   import br_resolve_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  brq_entry_t               push_data,
   output brq_entry_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   brq_entry_t mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign do_push = push & !full;
   assign do_pop  = pop & (count != '0);
   assign head    = mem[rp];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wp] <= push_data;
   end
endmodule

// File: rtl/br_resolve_unit.sv
// br_resolve_unit: checks queued predictions against EX/MEM outcomes, flushes and trains.
// Optional BR_RESOLVE_PERF_EN adds resolved/mispredict counters.
module br_resolve_unit
   import br_resolve_unit_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        push_valid,
   input  logic [31:0] push_pc,
   input  logic        push_pred_dir,
   input  logic [31:0] push_pred_tgt,
   output logic        push_ready,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic [6:0]  res_opcode,
   input  logic        res_br_en,
   input  logic [31:0] res_tgt,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic [6:0]  upd_opcode,
   output logic        upd_br_en,
   output logic [31:0] perf_resolved,
   output logic [31:0] perf_mispredict
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = RECOVER_CYCLES > 1 ? $clog2(RECOVER_CYCLES) : 1;
   brr_state_t     state;
   logic [RW-1:0]  rcnt;
   brq_entry_t     head;
   logic [CW-1:0]  count;
   logic           full, empty, run, push_en, res_en, mis;
   assign run        = state == BRR_RUN;
   assign empty      = count == '0;
   assign push_ready = run & !full;
   assign push_en    = push_valid & push_ready & !stall;
   assign res_en     = res_valid & !stall & run;
   // An empty queue means fetch fell through, so any resolution there is a mispredict.
   assign mis = res_en & (empty | head.pc != res_pc | head.dir != res_br_en |
                          (res_br_en & head.tgt != res_tgt));
   br_pred_queue #(.DEPTH(DEPTH)) u_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en & !mis),
      .pop       (res_en),
      .clear     (mis),
      .push_data ('{pc: push_pc, dir: push_pred_dir, tgt: push_pred_tgt}),
      .head      (head),
      .count     (count),
      .full      (full)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BRR_RUN;
         rcnt        <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         flush <= mis;
         if (mis) redirect_pc <= res_br_en ? res_tgt : fall_thru(res_pc);
         if (run) begin
            if (mis) begin
               state <= BRR_RECOVER;
               rcnt  <= '0;
            end
         end else if (!stall) begin
            if (rcnt == RW'(RECOVER_CYCLES - 1)) state <= BRR_RUN;
            rcnt <= rcnt + RW'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_valid  <= 1'b0;
         upd_pc     <= '0;
         upd_opcode <= '0;
         upd_br_en  <= 1'b0;
      end else begin
         upd_valid <= res_en;
         if (res_en) begin
            upd_pc     <= res_pc;
            upd_opcode <= res_opcode;
            upd_br_en  <= res_br_en;
         end
      end
   end
`ifdef BR_RESOLVE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_resolved   <= '0;
         perf_mispredict <= '0;
      end else begin
         perf_resolved   <= perf_resolved + 32'(res_en);
         perf_mispredict <= perf_mispredict + 32'(mis);
      end
   end
`else
   assign perf_resolved   = '0;
   assign perf_mispredict = '0;
`endif
endmodule

// File: tb/tb_br_resolve_unit.sv
// tb_br_resolve_unit: directed stimulus with a scoreboard-driven output monitor.
module tb_br_resolve_unit;
   localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6f, OP_JALR = 7'h67;
   logic clk = 0, rst_n = 0, stall = 0, push_valid = 0, push_pred_dir = 0;
   logic res_valid = 0, res_br_en = 0;
   logic [31:0] push_pc = 0, push_pred_tgt = 0, res_pc = 0, res_tgt = 0;
   logic [6:0] res_opcode = 0;
   logic push_ready, flush, upd_valid, upd_br_en;
   logic [31:0] redirect_pc, upd_pc, perf_resolved, perf_mispredict;
   logic [6:0] upd_opcode;
   typedef struct {logic fl; logic [31:0] rd; logic [31:0] pc; logic [6:0] op; logic br;} exp_t;
   exp_t sb[$];
   exp_t e;
   int n_chk = 0, n_fail = 0, exp_res = 0, exp_mis = 0;
   br_resolve_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .push_valid(push_valid), .push_pc(push_pc), .push_pred_dir(push_pred_dir),
      .push_pred_tgt(push_pred_tgt), .push_ready(push_ready),
      .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
      .res_br_en(res_br_en), .res_tgt(res_tgt),
      .flush(flush), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_opcode(upd_opcode), .upd_br_en(upd_br_en),
      .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict)
   );
   always #5 clk = ~clk;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   initial forever begin
      @(negedge clk);
      if (rst_n && (flush === 1'b1 || upd_valid === 1'b1)) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: flush=%0b upd_valid=%0b upd_pc=%0h", flush, upd_valid, upd_pc);
         end else begin
            e = sb.pop_front();
            chk("flush", 32'(flush), 32'(e.fl));
            chk("upd_valid", 32'(upd_valid), 32'd1);
            if (e.fl) chk("redirect_pc", redirect_pc, e.rd);
            chk("upd_pc", upd_pc, e.pc);
            chk("upd_opcode", 32'(upd_opcode), 32'(e.op));
            chk("upd_br_en", 32'(upd_br_en), 32'(e.br));
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic wait_rec();
      tick();
      tick();
   endtask
   task automatic do_push(logic [31:0] pc, logic dir, logic [31:0] tgt);
      push_valid = 1; push_pc = pc; push_pred_dir = dir; push_pred_tgt = tgt;
      tick();
      push_valid = 0;
   endtask
   task automatic do_res(logic [31:0] pc, logic [6:0] op, logic br, logic [31:0] tgt,
                         logic fl, logic [31:0] rd);
      res_valid = 1; res_pc = pc; res_opcode = op; res_br_en = br; res_tgt = tgt;
      sb.push_back('{fl, rd, pc, op, br});
      exp_res++;
      if (fl) exp_mis++;
      tick();
      res_valid = 0;
   endtask
   task automatic chk_perf();
`ifdef BR_RESOLVE_PERF_EN
      chk("perf_resolved", perf_resolved, 32'(exp_res));
      chk("perf_mispredict", perf_mispredict, 32'(exp_mis));
`else
      chk("perf_resolved", perf_resolved, 32'd0);
      chk("perf_mispredict", perf_mispredict, 32'd0);
`endif
   endtask
   initial begin
      tick();
      tick();
      chk("reset_push_ready", 32'(push_ready), 32'd1);
      chk("reset_flush", 32'(flush), 32'd0);
      chk("reset_upd_valid", 32'(upd_valid), 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      chk_perf();
      rst_n = 1;
      tick();
      // mid-run reset must discard queued entries
      do_push(32'h80, 1, 32'h900);
      do_push(32'h84, 0, 32'h0);
      #1 rst_n = 0;
      #1;
      chk("midreset_push_ready", 32'(push_ready), 32'd1);
      chk("midreset_flush", 32'(flush), 32'd0);
      chk("midreset_upd_valid", 32'(upd_valid), 32'd0);
      exp_res = 0;
      exp_mis = 0;
      tick();
      rst_n = 1;
      tick();
      do_res(32'h80, OP_BR, 1, 32'h900, 1, 32'h900);
      wait_rec();
      // correct not-taken
      do_push(32'h100, 0, 32'h0);
      do_res(32'h100, OP_BR, 0, 32'h0, 0, 32'h0);
      chk_perf();
      // direction mispredict, pushes during recovery are dropped
      do_push(32'h200, 0, 32'h0);
      do_res(32'h200, OP_BR, 1, 32'h400, 1, 32'h400);
      push_valid = 1; push_pc = 32'h2f0; push_pred_dir = 1; push_pred_tgt = 32'h2f8;
      chk("recover_ready_c0", 32'(push_ready), 32'd0);
      tick();
      chk("recover_ready_c1", 32'(push_ready), 32'd0);
      tick();
      push_valid = 0;
      chk("recover_ready_done", 32'(push_ready), 32'd1);
      do_push(32'h210, 0, 32'h0);
      do_res(32'h210, OP_BR, 0, 32'h0, 0, 32'h0);
      // target mispredict
      do_push(32'h300, 1, 32'h500);
      do_res(32'h300, OP_JALR, 1, 32'h504, 1, 32'h504);
      wait_rec();
      chk_perf();
      // full queue: simultaneous push+pop drops the push
      do_push(32'h10, 0, 32'h0);
      do_push(32'h14, 0, 32'h0);
      do_push(32'h18, 1, 32'h40);
      do_push(32'h1c, 0, 32'h0);
      chk("full_push_ready", 32'(push_ready), 32'd0);
      push_valid = 1; push_pc = 32'h20; push_pred_dir = 0; push_pred_tgt = 32'h0;
      do_res(32'h10, OP_BR, 0, 32'h0, 0, 32'h0);
      push_valid = 0;
      chk("after_pop_push_ready", 32'(push_ready), 32'd1);
      do_res(32'h14, OP_BR, 0, 32'h0, 0, 32'h0);
      do_res(32'h18, OP_JAL, 1, 32'h40, 0, 32'h0);
      do_res(32'h1c, OP_BR, 0, 32'h0, 0, 32'h0);
      do_res(32'h20, OP_BR, 0, 32'h0, 1, 32'h24);
      wait_rec();
      // stalled resolve yields a single training pulse
      do_push(32'h600, 0, 32'h0);
      res_valid = 1; res_pc = 32'h600; res_opcode = OP_BR; res_br_en = 0; res_tgt = 0;
      stall = 1;
      tick();
      tick();
      tick();
      stall = 0;
      do_res(32'h600, OP_BR, 0, 32'h0, 0, 32'h0);
      // fall-through wraps at the top of the address space
      do_res(32'hffff_fffc, OP_BR, 0, 32'h0, 1, 32'h0);
      chk_perf();
      wait_rec();
      tick();
      tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
